// File: rtl/rsa_modexp_arb.sv
// Round-robin arbiter that shares one modular-exponentiation engine between an
// encrypt requester (0, exponent key_e) and a decrypt requester (1, exponent key_d).
module rsa_modexp_arb #(
    parameter int          W       = 1024,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [2*W-1:0] key_e,
    input  logic [2*W-1:0] key_d,
    input  logic [2*W-1:0] key_n,
    input  logic           req0,
    input  logic [2*W-1:0] msg0,
    input  logic           req1,
    input  logic [2*W-1:0] msg1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           rsp_valid0,
    output logic           rsp_valid1,
    output logic [2*W-1:0] rsp_data,
    output logic           rsp_err,
    output logic           eng_start,
    output logic [2*W-1:0] eng_base,
    output logic [2*W-1:0] eng_exp,
    output logic [2*W-1:0] eng_mod,
    input  logic           eng_done,
    input  logic [2*W-1:0] eng_result,
    output logic           busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [31:0] TIMEOUT_C = TIMEOUT;

    logic [1:0]     state_q, state_d;
    logic           sel_q, sel_d;
    logic           last_q, last_d;
    logic [31:0]    timer_q, timer_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           eng_start_q, eng_start_d;
    logic [2*W-1:0] base_q, base_d;
    logic [2*W-1:0] exp_q, exp_d;
    logic [2*W-1:0] mod_q, mod_d;
    logic           rsp_valid0_q, rsp_valid0_d;
    logic           rsp_valid1_q, rsp_valid1_d;
    logic [2*W-1:0] rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic           pick1;
    logic [2*W-1:0] pick_msg;

    always_comb begin
        // On a tie the requester that was not served last wins.
        pick1    = req1 & (~req0 | ~last_q);
        pick_msg = pick1 ? msg1 : msg0;

        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        timer_d      = timer_q;
        base_d       = base_q;
        exp_d        = exp_q;
        mod_d        = mod_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        eng_start_d  = 1'b0;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_valid && (req0 || req1)) begin
                    sel_d  = pick1;
                    base_d = pick_msg;
                    exp_d  = pick1 ? key_d : key_e;
                    mod_d  = key_n;
                    gnt0_d = ~pick1;
                    gnt1_d = pick1;
                    if (pick_msg >= key_n) begin
                        // Out-of-range base: answer with an error, engine untouched.
                        state_d      = S_RESP;
                        rsp_err_d    = 1'b1;
                        rsp_data_d   = '0;
                        rsp_valid0_d = ~pick1;
                        rsp_valid1_d = pick1;
                    end else begin
                        state_d     = S_LAUNCH;
                        eng_start_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_d      = S_RESP;
                    rsp_data_d   = eng_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid0_d = ~sel_q;
                    rsp_valid1_d = sel_q;
                end else if (timer_q + 32'd1 >= TIMEOUT_C) begin
                    state_d      = S_RESP;
                    rsp_data_d   = '0;
                    rsp_err_d    = 1'b1;
                    rsp_valid0_d = ~sel_q;
                    rsp_valid1_d = sel_q;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_RESP: begin
                state_d    = S_IDLE;
                last_d     = sel_q;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            timer_q      <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            base_q       <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            eng_start_q  <= eng_start_d;
            base_q       <= base_d;
            exp_q        <= exp_d;
            mod_q        <= mod_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign eng_start  = eng_start_q;
    assign eng_base   = base_q;
    assign eng_exp    = exp_q;
    assign eng_mod    = mod_q;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rsa_modexp_arb.sv
// Bench for rsa_modexp_arb: W=8 toy RSA key (e=7, d=103, n=143), 5-cycle engine,
// timestamp-based transaction model checked every cycle plus directed literals.
module tb_rsa_modexp_arb;
    localparam int W  = 8;
    localparam int BW = 2 * W;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_valid = 1'b0;
    logic [BW-1:0] key_e = 16'd7, key_d = 16'd103, key_n = 16'd143;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [BW-1:0] msg0 = '0, msg1 = '0;
    logic          gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, eng_start, busy;
    logic [BW-1:0] rsp_data, eng_base, eng_exp, eng_mod;
    logic          eng_done = 1'b0;
    logic [BW-1:0] eng_result = '0;

    rsa_modexp_arb #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid),
        .key_e(key_e), .key_d(key_d), .key_n(key_n),
        .req0(req0), .msg0(msg0), .req1(req1), .msg1(msg1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_start(eng_start),
        .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
        .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int modpow(input int b, input int e, input int m);
        longint r, bb;
        int ee;
        r = 1; bb = b % m; ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >>> 1;
        end
        return int'(r);
    endfunction

    // Engine: fixed 5-cycle latency; eng_en=0 makes it mute, inject forces a stray done.
    bit            eng_en = 1'b1;
    bit            inject = 1'b0;
    logic [BW-1:0] inj_val = 16'h00AB;
    initial begin
        bit            pend;
        int            ecnt;
        logic [BW-1:0] eres;
        pend = 0; ecnt = 0; eres = '0;
        forever begin
            @(negedge clk);
            if (eng_start && eng_en) begin
                pend = 1; ecnt = 0;
                eres = BW'(modpow(int'(eng_base), int'(eng_exp), int'(eng_mod)));
            end
            @(posedge clk);
            #1;
            eng_done = inject;
            if (inject) eng_result = inj_val;
            if (pend) begin
                ecnt++;
                if (ecnt == 5) begin
                    eng_done = 1'b1; eng_result = eres; pend = 0;
                end
            end
        end
    end

    // Transaction model: grant edge g, response edge r; outputs follow from timestamps.
    int            e = 0, g = 0, r = 0;
    bit            act = 0, who = 0, last = 1, err_path = 0, resolved = 0;
    logic [BW-1:0] mb = '0, me = '0, mn = '0, rdata = '0;
    bit            rerr = 0;
    bit            x_gnt0 = 0, x_gnt1 = 0, x_start = 0, x_rv0 = 0, x_rv1 = 0, x_busy = 0;
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                e = 0; act = 0; last = 1; resolved = 0; err_path = 0;
                mb = '0; me = '0; mn = '0;
                x_gnt0 = 0; x_gnt1 = 0; x_start = 0; x_rv0 = 0; x_rv1 = 0; x_busy = 0;
            end else begin
                e++;
                if (act) begin
                    if (!resolved && e >= g + 2) begin
                        if (eng_done) begin
                            resolved = 1; r = e; rdata = eng_result; rerr = 0;
                        end else if (e == g + 1 + TO) begin
                            resolved = 1; r = e; rdata = '0; rerr = 1;
                        end
                    end else if (resolved && e == r + 1) begin
                        act = 0; last = who;
                    end
                end else if (key_valid && (req0 || req1)) begin
                    who = (req0 && req1) ? !last : req1;
                    mb = who ? msg1 : msg0;
                    me = who ? key_d : key_e;
                    mn = key_n;
                    g = e; act = 1;
                    err_path = (mb >= mn);
                    resolved = err_path;
                    if (err_path) begin r = e; rdata = '0; rerr = 1; end
                end
                x_gnt0  = act && e == g && !who;
                x_gnt1  = act && e == g && who;
                x_start = act && e == g && !err_path;
                x_rv0   = act && resolved && e == r && !who;
                x_rv1   = act && resolved && e == r && who;
                x_busy  = act;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_gnt0", int'(gnt0), int'(x_gnt0));
            chk("m_gnt1", int'(gnt1), int'(x_gnt1));
            chk("m_eng_start", int'(eng_start), int'(x_start));
            chk("m_rsp_valid0", int'(rsp_valid0), int'(x_rv0));
            chk("m_rsp_valid1", int'(rsp_valid1), int'(x_rv1));
            chk("m_busy", int'(busy), int'(x_busy));
            chk("m_eng_base", int'(eng_base), int'(mb));
            chk("m_eng_exp", int'(eng_exp), int'(me));
            chk("m_eng_mod", int'(eng_mod), int'(mn));
            if (x_rv0 || x_rv1) begin
                chk("m_rsp_data", int'(rsp_data), int'(rdata));
                chk("m_rsp_err", int'(rsp_err), int'(rerr));
            end
        end
    end

    function automatic bit sig(input int which);
        case (which)
            0: return gnt0;
            1: return gnt1;
            2: return rsp_valid0;
            3: return rsp_valid1;
            default: return gnt0 | gnt1;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                cycles = i + 1;
                return;
            end
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int c, seen, who_i;
        int bad_msgs[2] = '{150, 143};
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        @(posedge clk); #1 rst = 1'b1;

        chk("pin_encrypt", modpow(9, 7, 143), 48);
        chk("pin_decrypt", modpow(48, 103, 143), 9);

        // Single encrypt; keys, key_valid and msg disturbed while in flight.
        @(negedge clk);
        key_valid = 1'b1; req0 = 1'b1; msg0 = 16'd9;
        wait_for(0, 10, "t1_gnt", c);
        chk("t1_gnt_lat", c, 1);
        chk("t1_eng_start", int'(eng_start), 1);
        chk("t1_base", int'(eng_base), 9);
        chk("t1_exp", int'(eng_exp), 7);
        chk("t1_mod", int'(eng_mod), 143);
        req0 = 1'b0; msg0 = 16'd200; key_n = 16'd50; key_e = 16'd3; key_valid = 1'b0;
        wait_for(2, 40, "t1_rsp", c);
        chk("t1_rsp_lat", c, 6);
        chk("t1_data", int'(rsp_data), 48);
        chk("t1_err", int'(rsp_err), 0);
        key_n = 16'd143; key_e = 16'd7; key_valid = 1'b1;
        @(negedge clk);
        chk("t1_idle_busy", int'(busy), 0);

        // Both requesting after reset: 0 first, then alternate.
        reset_dut();
        req0 = 1'b1; msg0 = 16'd9; req1 = 1'b1; msg1 = 16'd48;
        for (int i = 0; i < 4; i++) begin
            wait_for(4, 20, "t2_gnt", c);
            who_i = int'(gnt1);
            chk("t2_who", who_i, i % 2);
            wait_for(who_i == 1 ? 3 : 2, 40, "t2_rsp", c);
            chk("t2_data", int'(rsp_data), who_i == 1 ? 9 : 48);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Base out of range (including base == n): error, engine never started.
        foreach (bad_msgs[k]) begin
            @(negedge clk);
            req0 = 1'b1; msg0 = BW'(bad_msgs[k]);
            wait_for(0, 10, "t3_gnt", c);
            req0 = 1'b0;
            chk("t3_eng_start", int'(eng_start), 0);
            chk("t3_rsp_valid0", int'(rsp_valid0), 1);
            chk("t3_err", int'(rsp_err), 1);
            chk("t3_data", int'(rsp_data), 0);
            @(negedge clk);
            chk("t3_busy_after", int'(busy), 0);
        end

        // Mute engine: timeout after 16 WAIT cycles.
        eng_en = 1'b0;
        @(negedge clk);
        req0 = 1'b1; msg0 = 16'd9;
        wait_for(0, 10, "t4_gnt", c);
        req0 = 1'b0;
        wait_for(2, 40, "t4_rsp", c);
        chk("t4_timeout_lat", c, 17);
        chk("t4_err", int'(rsp_err), 1);
        chk("t4_data", int'(rsp_data), 0);
        @(negedge clk);
        chk("t4_busy_after", int'(busy), 0);
        eng_en = 1'b1;

        // No grant while key_valid is low; served once it rises.
        @(negedge clk);
        key_valid = 1'b0; req1 = 1'b1; msg1 = 16'd48;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1 || busy) seen++;
        end
        chk("t5_no_grant", seen, 0);
        key_valid = 1'b1;
        wait_for(1, 5, "t5_gnt", c);
        chk("t5_gnt_lat", c, 1);
        req1 = 1'b0;
        wait_for(3, 40, "t5_rsp", c);
        chk("t5_data", int'(rsp_data), 9);
        chk("t5_err", int'(rsp_err), 0);

        // Reset in WAIT, then the stale engine done plus a stray done pulse.
        @(negedge clk);
        req0 = 1'b1; msg0 = 16'd9;
        wait_for(0, 10, "t6_gnt", c);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            inject = (i == 3);
            if (rsp_valid0 || rsp_valid1 || gnt0 || gnt1 || eng_start || busy) seen++;
        end
        inject = 1'b0;
        chk("t6_quiet", seen, 0);
        chk("t6_rsp_data", int'(rsp_data), 0);
        chk("t6_rsp_err", int'(rsp_err), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
